// File: rtl/bin_to_bcd4_pkg.sv
// -----------------------------------------------------------------------------
// bin_to_bcd4_pkg
// Shared definitions for the binary-to-BCD converter: FSM state encoding,
// the error digit shown on overflow, the default display limit and the
// digit/accumulator geometry.
// -----------------------------------------------------------------------------
package bin_to_bcd4_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // Digit value loaded into every position when the input cannot be shown.
  // The scanner renders this nibble as the letter "E".
  localparam logic [3:0] BCD_ERR = 4'hE;

  // Largest value a four-digit display can show.
  localparam int DEF_MAX_VAL = 9999;

  // Number of decimal digits and width of the BCD accumulator.
  localparam int DIGITS = 4;
  localparam int ACC_W  = 4 * DIGITS;

endpackage : bin_to_bcd4_pkg

// File: rtl/bin_to_bcd4_if.sv
// -----------------------------------------------------------------------------
// bin_to_bcd4_if
// Request/result bundle of the binary-to-BCD converter.
//   start     : conversion request (master -> slave)
//   bin_in    : unsigned value to convert (master -> slave)
//   busy      : conversion in progress (slave -> master)
//   done      : one-cycle completion pulse (slave -> master)
//   overflow  : last converted value exceeded the display limit
//   dig1..4   : thousands, hundreds, tens, units digits
// -----------------------------------------------------------------------------
interface bin_to_bcd4_if #(
  parameter int BIN_W = 14
) ();

  logic             start;
  logic [BIN_W-1:0] bin_in;
  logic             busy;
  logic             done;
  logic             overflow;
  logic [3:0]       dig1;
  logic [3:0]       dig2;
  logic [3:0]       dig3;
  logic [3:0]       dig4;

  modport master (
    output start, bin_in,
    input  busy, done, overflow, dig1, dig2, dig3, dig4
  );

  modport slave (
    input  start, bin_in,
    output busy, done, overflow, dig1, dig2, dig3, dig4
  );

endinterface : bin_to_bcd4_if

// File: rtl/bcd_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
// Combinational double-dabble nibble correction: values of 5 or more get 3
// added so that the following left shift carries correctly into the next
// decimal digit. No carry leaves the nibble.
//   nib_i : accumulator nibble before correction
//   nib_o : corrected nibble
// -----------------------------------------------------------------------------
module bcd_add3 (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  assign nib_o = (nib_i >= 4'd5) ? (nib_i + 4'd3) : nib_i;

endmodule : bcd_add3

// File: rtl/bin_to_bcd4.sv
// -----------------------------------------------------------------------------
// bin_to_bcd4
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per
// clock. A request accepted in IDLE runs BIN_W shift cycles, then the four
// registered digits and the overflow flag are updated together on the edge
// that enters DONE. Digits hold their value between completions so the
// downstream scanner never sees partial results.
//   ClkPort : system clock
//   reset   : asynchronous active-low reset
//   bus     : request/result bundle (slave side)
// Parameters:
//   BIN_W   : input width (4..14)
//   MAX_VAL : largest displayable value; larger inputs show "EEEE"
// -----------------------------------------------------------------------------
module bin_to_bcd4
  import bin_to_bcd4_pkg::*;
#(
  parameter int BIN_W   = 14,
  parameter int MAX_VAL = DEF_MAX_VAL
) (
  input  logic           ClkPort,
  input  logic           reset,
  bin_to_bcd4_if.slave   bus
);

  localparam int          CNT_W = $clog2(BIN_W + 1);
  localparam logic [31:0] MAX_U = 32'(MAX_VAL);
  localparam int          PAIR_W = ACC_W + BIN_W;

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic               ovf_q, ovf_d;
  logic [3:0]         dig_q [DIGITS];
  logic [3:0]         dig_d [DIGITS];

  logic [ACC_W-1:0]   acc_corr;
  logic [PAIR_W-1:0]  pair_shift;
  logic [ACC_W-1:0]   acc_shift;
  logic [BIN_W-1:0]   bin_shift;

  // Per-nibble add-3 correction ahead of each shift.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_add3
      bcd_add3 u_add3 (
        .nib_i (acc_q[4*gi +: 4]),
        .nib_o (acc_corr[4*gi +: 4])
      );
    end
  endgenerate

  // The corrected accumulator and the remaining binary bits shift as one
  // register, so the binary MSB lands in the accumulator LSB.
  assign pair_shift = {acc_corr, bin_q} << 1;
  assign acc_shift  = pair_shift[PAIR_W-1:BIN_W];
  assign bin_shift  = pair_shift[BIN_W-1:0];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge ClkPort or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      bin_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        dig_q[i] <= 4'h0;
      end
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      ovf_q      <= ovf_d;
      for (int i = 0; i < DIGITS; i++) begin
        dig_q[i] <= dig_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    ovf_d      = ovf_q;
    for (int i = 0; i < DIGITS; i++) begin
      dig_d[i] = dig_q[i];
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          bin_d      = bus.bin_in;
          acc_d      = '0;
          // Decided up front: values needing a fifth digit are never shown.
          ovf_pend_d = (32'(bus.bin_in) > MAX_U);
          cnt_d      = CNT_W'(BIN_W);
          state_d    = S_SHIFT;
        end
      end

      S_SHIFT: begin
        acc_d = acc_shift;
        bin_d = bin_shift;
        cnt_d = cnt_q - CNT_W'(1);
        // cnt_q==1 marks the last shift; publish its result directly so the
        // digits change exactly once, on the DONE-entry edge.
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
          ovf_d   = ovf_pend_q;
          for (int i = 0; i < DIGITS; i++) begin
            dig_d[i] = ovf_pend_q ? BCD_ERR : acc_shift[4*i +: 4];
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs (all decoded from registers)
  // ---------------------------------------------------------------------------
  assign bus.busy     = (state_q == S_SHIFT);
  assign bus.done     = (state_q == S_DONE);
  assign bus.overflow = ovf_q;
  assign bus.dig1     = dig_q[3];
  assign bus.dig2     = dig_q[2];
  assign bus.dig3     = dig_q[1];
  assign bus.dig4     = dig_q[0];

endmodule : bin_to_bcd4

// File: tb/tb_bin_to_bcd4.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd4
// Directed self-checking bench for bin_to_bcd4 (BIN_W=14, MAX_VAL=9999).
// -----------------------------------------------------------------------------
module tb_bin_to_bcd4;

  logic clk;
  logic rst_n;

  int compared   = 0;
  int mismatched = 0;

  logic [15:0] prev_digs;
  logic        prev_ovf;

  bin_to_bcd4_if #(.BIN_W(14)) bus_if ();

  bin_to_bcd4 #(
    .BIN_W   (14),
    .MAX_VAL (9999)
  ) dut (
    .ClkPort (clk),
    .reset   (rst_n),
    .bus     (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] get_digs();
    return {bus_if.dig1, bus_if.dig2, bus_if.dig3, bus_if.dig4};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while the DUT is idle. Raises start for one edge,
  // then follows the conversion to its done pulse. Optional extra start
  // pulses (bin_in=5) are raised during cycle indices pulse_a/pulse_b,
  // where index 0 is the cycle right after the accepted start edge.
  task automatic convert(input string tag, input logic [13:0] v,
                         input logic [15:0] exp_digs, input logic exp_ovf,
                         input int pulse_a, input int pulse_b);
    int cycles;
    bit got;
    bus_if.start  = 1'b1;
    bus_if.bin_in = v;
    @(posedge clk);
    #1;
    bus_if.start  = 1'b0;
    bus_if.bin_in = ~v;
    cycles = 0;
    got    = 1'b0;
    while (!got && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (bus_if.done) begin
        got = 1'b1;
      end else begin
        check({tag, ".busy"}, 32'(bus_if.busy), 32'd1);
        check({tag, ".hold_digs"}, 32'(get_digs()), 32'(prev_digs));
        check({tag, ".hold_ovf"}, 32'(bus_if.overflow), 32'(prev_ovf));
        bus_if.start  = ((cycles - 1) == pulse_a) || ((cycles - 1) == pulse_b);
        bus_if.bin_in = bus_if.start ? 14'd5 : ~v;
      end
    end
    check({tag, ".done_seen"}, 32'(got), 32'd1);
    check({tag, ".latency"}, 32'(cycles - 1), 32'd14);
    check({tag, ".busy_in_done"}, 32'(bus_if.busy), 32'd0);
    check({tag, ".digs"}, 32'(get_digs()), 32'(exp_digs));
    check({tag, ".ovf"}, 32'(bus_if.overflow), 32'(exp_ovf));
    if (pulse_b == 14) begin
      bus_if.start  = 1'b1;
      bus_if.bin_in = 14'd5;
    end
    @(negedge clk);
    bus_if.start = 1'b0;
    check({tag, ".done_drop"}, 32'(bus_if.done), 32'd0);
    check({tag, ".idle_busy"}, 32'(bus_if.busy), 32'd0);
    check({tag, ".digs_held"}, 32'(get_digs()), 32'(exp_digs));
    prev_digs = exp_digs;
    prev_ovf  = exp_ovf;
    $display("conv %-8s in=%0d digs=%04h ovf=%0b latency=%0d", tag, v, get_digs(),
             bus_if.overflow, cycles - 1);
  endtask

  initial begin
    bit saw_done;

    rst_n         = 1'b0;
    bus_if.start  = 1'b0;
    bus_if.bin_in = '0;
    prev_digs     = 16'h0000;
    prev_ovf      = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.digs", 32'(get_digs()), 32'h0);
    check("rst.busy", 32'(bus_if.busy), 32'd0);
    check("rst.done", 32'(bus_if.done), 32'd0);
    check("rst.ovf", 32'(bus_if.overflow), 32'd0);
    $display("reset  digs=%04h busy=%0b done=%0b ovf=%0b", get_digs(), bus_if.busy,
             bus_if.done, bus_if.overflow);
    rst_n = 1'b1;
    @(negedge clk);

    // Main conversions and boundaries
    convert("zero",  14'd0,     16'h0000, 1'b0, -1, -1);
    convert("v1234", 14'd1234,  16'h1234, 1'b0, -1, -1);
    convert("v9999", 14'd9999,  16'h9999, 1'b0, -1, -1);
    convert("v10000", 14'd10000, 16'hEEEE, 1'b1, -1, -1);
    convert("v16383", 14'd16383, 16'hEEEE, 1'b1, -1, -1);
    convert("v42",   14'd42,    16'h0042, 1'b0, -1, -1);

    // Start pulses during SHIFT (cycle 3) and DONE (cycle 14) are ignored
    convert("v1111", 14'h0457,  16'h1111, 1'b0, 3, 14);
    @(negedge clk);
    check("v1111.no_restart", 32'(bus_if.busy), 32'd0);
    check("v1111.no_redo", 32'(bus_if.done), 32'd0);

    // Reset in the middle of a conversion
    convert("v5555", 14'd5555,  16'h5555, 1'b0, -1, -1);
    bus_if.start  = 1'b1;
    bus_if.bin_in = 14'd7;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort.digs", 32'(get_digs()), 32'h0);
    check("abort.busy", 32'(bus_if.busy), 32'd0);
    check("abort.done", 32'(bus_if.done), 32'd0);
    check("abort.ovf", 32'(bus_if.overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_if.done) saw_done = 1'b1;
    end
    check("abort.no_done", 32'(saw_done), 32'd0);
    check("abort.idle_busy", 32'(bus_if.busy), 32'd0);
    $display("abort  digs=%04h busy=%0b saw_done=%0b", get_digs(), bus_if.busy, saw_done);
    prev_digs = 16'h0000;
    prev_ovf  = 1'b0;
    convert("v8", 14'd8, 16'h0008, 1'b0, -1, -1);

    // Back-to-back: second start in the first IDLE cycle after done
    convert("v321",  14'd321,  16'h0321, 1'b0, -1, -1);
    convert("v4096", 14'd4096, 16'h4096, 1'b0, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_bin_to_bcd4

// File: doc/bin_to_bcd4.md
Name: bin_to_bcd4

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It sits directly upstream of the four-digit seven-segment scanner.
- Converts a binary count (score, timer, counter value) into four decimal digits dig1..dig4.
- dig1 is the most significant digit (leftmost display), dig4 the least significant (rightmost).
- Digit outputs are registered and hold the last result until the next conversion completes, so the scanner never sees intermediate values.

Parameters:
- BIN_W, 14: width of bin_in. Legal range 4..14.
- MAX_VAL, 9999: largest value that can be displayed. Any input above it is an overflow.

Ports:
- ClkPort  input  1  system clock (100 MHz board clock domain).
- reset  input  1  asynchronous, active-low reset. Asserting it (0) clears all state immediately.
- start  input  1  conversion request. Sampled only in IDLE.
- bin_in  input  BIN_W  unsigned value to convert. Captured on the accepted start edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; outputs are valid and updated.
- overflow  output  1  last converted value was greater than MAX_VAL. Held until the next completion.
- dig1  output  4  thousands digit.
- dig2  output  4  hundreds digit.
- dig3  output  4  tens digit.
- dig4  output  4  units digit.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - busy=0, done=0, overflow=0.
  - dig1..dig4=4'h0.
  - Internal shift register and counter cleared.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge E0: capture bin_in into the shift register and clear the 16-bit BCD accumulator.
  - Set ovf_pend = (bin_in > MAX_VAL).
  - Load cnt = BIN_W; go to SHIFT; busy=1 from E0.
  - start=0: remain in IDLE.
- SHIFT:
  - Each cycle, first add 3 to every accumulator nibble that is >= 5.
  - Then shift {accumulator, binary} left by 1 and decrement cnt.
  - When cnt reaches 1 at an edge (the BIN_W-th shift), go to DONE.
  - start is ignored; bin_in changes are ignored.
- Transition into DONE (edge E0+BIN_W):
  - Load dig1..dig4 from accumulator nibbles [15:12],[11:8],[7:4],[3:0].
  - If ovf_pend, load 4'hE into all four digits instead (scanner shows "EEEE") and set overflow=1; otherwise overflow=0.
  - done=1 and busy=0 during the DONE cycle.
- DONE: lasts exactly one cycle, then IDLE; done returns to 0. start is ignored in DONE.
- Latency: done is high in the cycle after edge E0+BIN_W. Default BIN_W=14 gives 14 cycles from the start edge to the result edge. Minimum start-to-start spacing is BIN_W+2 cycles.
- Arithmetic:
  - Accumulator is 16 bits (4 nibbles). Add-3 is applied per nibble, with no carry between nibbles.
  - Values above 9999 would need a fifth digit; they are not converted and are always flagged through the overflow path.
- Boundaries:
  - bin_in=0 gives 0,0,0,0.
  - bin_in=MAX_VAL gives 9,9,9,9 with overflow=0.
  - bin_in=MAX_VAL+1 takes the overflow path.
  - If BIN_W <= 13, overflow is never set.
- Reset mid-conversion: aborts immediately; digits clear to 0 and no done pulse follows.
- Outputs change only at the DONE-entry edge or on reset.

Decomposition:
- Shared package contents:
  - State encoding constants S_IDLE, S_SHIFT, S_DONE.
  - BCD_ERR = 4'hE.
  - Default MAX_VAL = 9999.
  - Digit count = 4.
- Sub-module bcd_add3: combinational 4-bit nibble correction (in>=5 ? in+3 : in), instantiated 4 times on the accumulator. This is the only sub-module; the FSM and datapath stay in bin_to_bcd4.

Test Plan:
- Reset then bin_in=0, start pulse: done after 14 cycles; digits 0,0,0,0; overflow=0; busy high for cycles 0..13.
- bin_in=1234: dig1..dig4=1,2,3,4. bin_in=9999: 9,9,9,9 with overflow=0.
- bin_in=10000 and bin_in=16383: digits E,E,E,E and overflow=1. A following 42 gives 0,0,4,2 and clears overflow.
- Start 0x0457 (1111), then pulse start with bin_in=5 on cycles 3 and 14 (the DONE cycle): only one done pulse; result 1,1,1,1; second request ignored.
- After 5555 completes, start 7; assert reset=0 on cycle 6: digits go to 0 immediately, busy=0, no done; after release a fresh start of 8 gives 0,0,0,8.
- Back-to-back: new start in the first IDLE cycle after done: conversions 321 then 4096 both complete with correct digits. dig values are held stable between the two done pulses.
